acc_writeback: RTL

Downstream drain stage for the systolic accumulator. Accepts one complete output row (N lanes of 16-bit signed Q8.8) per handshake, applies per-column bias add with saturation and an optional leaky ReLU, then serializes the row into the unified buffer one element per beat with address generation. Runs a programmed number of rows per job, then pulses done.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/acc_postproc.sv | 31 +++
 rtl/acc_writeback.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath blocks.
package tpu_pkg;

  // Accumulator / unified-buffer element width; values are signed Q8.8.
  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VEC = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } wb_state_t;

endpackage

// File: rtl/acc_postproc.sv
// Per-element post-processing: bias add with saturation, optional leaky ReLU.
module acc_postproc
  import tpu_pkg::*;
#(
  parameter int unsigned LEAK_SHIFT = 2
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] bias,
  input  logic              act_en,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat;

  // Sign-extended add, clamp on the two top bits disagreeing, then leak negatives.
  always_comb begin
    sum = {x[DATA_W-1], x} + {bias[DATA_W-1], bias};
    sat = sum[DATA_W-1:0];
    if (sum[DATA_W:DATA_W-1] == 2'b01) begin
      sat = SAT_MAX;
    end else if (sum[DATA_W:DATA_W-1] == 2'b10) begin
      sat = SAT_MIN;
    end
    y = sat;
    if (act_en && sat[DATA_W-1]) begin
      y = DATA_W'($signed(sat) >>> LEAK_SHIFT);
    end
  end

endmodule

// File: rtl/acc_writeback.sv
// Drain stage: takes accumulator rows, post-processes each lane and writes
// them one element per beat into the unified buffer at consecutive addresses.
module acc_writeback
  import tpu_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LEAK_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [7:0]          num_rows,
  input  logic                act_en,
  input  logic [N*DATA_W-1:0] bias_data,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [N*DATA_W-1:0] vec_data,
  output logic                ub_wr_en,
  input  logic                ub_wr_ready,
  output logic [ADDR_W-1:0]   ub_wr_addr,
  output logic [DATA_W-1:0]   ub_wr_data,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ROW_W  = 8;

  wb_state_t state, state_nxt;

  logic [DATA_W-1:0] row_buf [N];
  logic [DATA_W-1:0] bias_q  [N];
  logic [ROW_W-1:0]  num_rows_q;
  logic [ROW_W-1:0]  row_idx;
  logic              act_en_q;
  logic [LANE_W-1:0] lane_cnt;

  logic              job_start;
  logic              vec_fire;
  logic              wr_fire;
  logic              last_lane;
  logic              last_row;
  logic [DATA_W-1:0] pp_x;
  logic [DATA_W-1:0] pp_bias;

  assign job_start = (state == IDLE) && start;
  assign vec_fire  = vec_valid && vec_ready;
  assign wr_fire   = ub_wr_en && ub_wr_ready;
  assign last_lane = (lane_cnt == LANE_W'(N - 1));
  assign last_row  = (row_idx == num_rows_q - ROW_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_rows == '0) ? DONE : WAIT_VEC;
        end
      end
      WAIT_VEC: begin
        if (vec_valid) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (wr_fire && last_lane) begin
          state_nxt = last_row ? DONE : WAIT_VEC;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    vec_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE:     busy      = 1'b0;
      WAIT_VEC: vec_ready = 1'b1;
      DONE:     done      = 1'b1;
      default:  ;
    endcase
  end

  // Job configuration, captured once at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows_q <= '0;
      act_en_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        bias_q[i] <= '0;
      end
    end else if (job_start) begin
      num_rows_q <= num_rows;
      act_en_q   <= act_en;
      for (int i = 0; i < N; i++) begin
        bias_q[i] <= bias_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Row capture, beat sequencing and address generation. The address runs
  // sequentially across rows, so a single increment per transfer yields
  // base + row*N + lane with natural wrap at the address width.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        row_buf[i] <= '0;
      end
      lane_cnt   <= '0;
      row_idx    <= '0;
      ub_wr_en   <= 1'b0;
      ub_wr_addr <= '0;
    end else begin
      if (job_start) begin
        row_idx    <= '0;
        ub_wr_addr <= base_addr;
      end
      if (vec_fire) begin
        for (int i = 0; i < N; i++) begin
          row_buf[i] <= vec_data[i*DATA_W +: DATA_W];
        end
        lane_cnt <= '0;
        ub_wr_en <= 1'b1;
      end
      if (wr_fire) begin
        ub_wr_addr <= ub_wr_addr + ADDR_W'(1);
        lane_cnt   <= lane_cnt + LANE_W'(1);
        if (last_lane) begin
          ub_wr_en <= 1'b0;
          row_idx  <= row_idx + ROW_W'(1);
        end
      end
    end
  end

  // Single post-processing unit shared across lanes.
  always_comb begin
    pp_x    = row_buf[lane_cnt];
    pp_bias = bias_q[lane_cnt];
  end

  acc_postproc #(
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_postproc (
    .x     (pp_x),
    .bias  (pp_bias),
    .act_en(act_en_q),
    .y     (ub_wr_data)
  );

endmodule
